// File: rtl/stg0ia.sv
// stg0ia: instruction-address (fetch PC) stage feeding stg1if.
// Latency: branch target on iw_branch_pc in cycle N appears on ow_pc in cycle N+1; PC advances one per accepted fetch.
// Backpressure: iw_stall / iw_mem_ready=0 / iw_flush hold the PC and suppress ow_ia_valid; requests keep flowing.
//
// Ports:
//   iw_clk, iw_rst        clock, asynchronous active-high reset
//   iw_stall, iw_flush    downstream hold / squash of the current fetch
//   iw_branch_valid/_pc   redirect from a later stage (highest priority)
//   iw_mem_ready          instruction memory has data for ow_mem_addr this cycle
//   iw_halt               halt request, honoured only when STG0IA_HALT_EN is defined
//   ow_mem_addr, ow_mem_req  fetch address / request qualifier to instruction memory
//   ow_pc, ow_ia_valid    fetch PC and accept strobe towards stg1if
//
// Address width comes from `SIZE_ADDR / `HBIT_ADDR (defaults below if not set by the build).
// Optional feature macro: STG0IA_HALT_EN (enables the HALT state).

`ifndef SIZE_ADDR
`define SIZE_ADDR 32
`endif
`ifndef HBIT_ADDR
`define HBIT_ADDR (`SIZE_ADDR-1)
`endif

`default_nettype none

module stg0ia (
    input  logic                iw_clk,
    input  logic                iw_rst,
    input  logic                iw_stall,
    input  logic                iw_flush,
    input  logic                iw_branch_valid,
    input  logic [`HBIT_ADDR:0] iw_branch_pc,
    input  logic                iw_mem_ready,
    input  logic                iw_halt,
    output logic [`HBIT_ADDR:0] ow_mem_addr,
    output logic                ow_mem_req,
    output logic [`HBIT_ADDR:0] ow_pc,
    output logic                ow_ia_valid
);

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [`HBIT_ADDR:0] r_pc;
    logic [`HBIT_ADDR:0] w_pc_nxt;
    logic                w_halt_req;
    logic                w_accept;

`ifdef STG0IA_HALT_EN
    assign w_halt_req = iw_halt;
`else
    // Port kept for a stable interface; the request is deliberately dropped.
    logic unused_halt;
    assign unused_halt = iw_halt;
    assign w_halt_req  = 1'b0;
`endif

    // State and PC register.
    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            r_state <= S_BOOT;
            r_pc    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
        end
    end

    // Next-state / next-PC. A redirect beats everything, in every state.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        if (iw_branch_valid) begin
            w_state_nxt = S_RUN;
            w_pc_nxt    = iw_branch_pc;
        end else begin
            case (r_state)
                S_BOOT: w_state_nxt = S_RUN;
                S_RUN: begin
                    if (w_halt_req) begin
                        // Halt takes effect at this edge; the current fetch is not taken.
                        w_state_nxt = S_HALT;
                    end else if (w_accept) begin
                        // Natural wrap from all-ones back to zero.
                        w_pc_nxt = r_pc + {{(`SIZE_ADDR-1){1'b0}}, 1'b1};
                    end
                end
`ifdef STG0IA_HALT_EN
                S_HALT: w_state_nxt = S_HALT;
`else
                // Unreachable in this build; recover to RUN if ever entered.
                S_HALT: w_state_nxt = S_RUN;
`endif
                default: w_state_nxt = S_BOOT;
            endcase
        end
    end

    // Outputs. Gating with iw_rst keeps the accept strobe low in the very
    // cycle reset lands, independent of when the register reset resolves.
    always_comb begin
        ow_mem_addr = r_pc;
        ow_pc       = r_pc;
        ow_mem_req  = (r_state == S_RUN) && !iw_rst;
        w_accept    = (r_state == S_RUN) && !iw_rst && iw_mem_ready && !iw_stall
                      && !iw_flush && !iw_branch_valid && !w_halt_req;
        ow_ia_valid = w_accept;
    end

endmodule

`default_nettype wire

// File: doc/stg0ia.md
STG0IA -- requirements
Module: stg0ia

Interface
REQ-001 SHALL have parameter-free ports; address width from `SIZE_ADDR (bit range `HBIT_ADDR:0).
REQ-002 iw_clk  input  1  single clock; all state updates on rising edge.
REQ-003 iw_rst  input  1  reset, asynchronous, active-high.
REQ-004 iw_stall  input  1  downstream hold; no PC advance, no valid fetch.
REQ-005 iw_flush  input  1  squash current fetch; PC held unless redirect.
REQ-006 iw_branch_valid  input  1  redirect request from a later stage.
REQ-007 iw_branch_pc  input  `SIZE_ADDR  redirect target.
REQ-008 iw_mem_ready  input  1  instruction memory returns data for ow_mem_addr this cycle.
REQ-009 iw_halt  input  1  halt request (see Configuration).
REQ-010 ow_mem_addr  output  `SIZE_ADDR  fetch address to instruction memory.
REQ-011 ow_mem_req  output  1  fetch request qualifier.
REQ-012 ow_pc  output  `SIZE_ADDR  PC of the fetch presented to stg1if.
REQ-013 ow_ia_valid  output  1  fetch accepted this cycle; stg1if latches ow_pc and memory data.

Function
REQ-014 SHALL hold a PC register r_pc; ow_mem_addr and ow_pc SHALL both equal r_pc combinationally.
REQ-015 SHALL implement FSM states BOOT, RUN, HALT; BOOT lasts exactly one cycle after reset release, then RUN.
REQ-016 ow_mem_req SHALL be 1 only in RUN.
REQ-017 ow_ia_valid SHALL be 1 iff state==RUN and iw_mem_ready and !iw_stall and !iw_flush and !iw_branch_valid.
REQ-018 On an edge with ow_ia_valid=1, r_pc SHALL become r_pc+1, modulo 2^`SIZE_ADDR (all-ones wraps to 0).
REQ-019 iw_branch_valid SHALL have highest priority in RUN, BOOT and HALT: r_pc <= iw_branch_pc, next state RUN, ow_ia_valid=0 that cycle.
REQ-020 iw_flush without iw_branch_valid SHALL hold r_pc and force ow_ia_valid=0.
REQ-021 iw_stall or iw_mem_ready=0 (no branch) SHALL hold r_pc; requests continue (ow_mem_req stays 1).
REQ-022 Simultaneous stall, flush and branch SHALL resolve as branch; flush+stall SHALL hold r_pc.
REQ-023 Latency: target driven on iw_branch_pc in cycle N SHALL appear on ow_pc in cycle N+1 and may be valid in N+1.
REQ-024 Back-to-back accepted fetches SHALL yield one instruction per cycle with consecutive PCs.

Reset
REQ-025 iw_rst SHALL asynchronously force r_pc=0, state=BOOT; outputs during reset: ow_pc=0, ow_mem_addr=0, ow_mem_req=0, ow_ia_valid=0.
REQ-026 Reset asserted mid-operation (any state, any input) SHALL override all inputs immediately, with no fetch accepted in that cycle.

Configuration
REQ-027 Macro STG0IA_HALT_EN SHALL gate halt support.
REQ-028 With STG0IA_HALT_EN defined: iw_halt=1 in RUN (no branch) SHALL move to HALT after the current edge, no PC advance that cycle; HALT SHALL drive ow_mem_req=0, ow_ia_valid=0; HALT exits only by branch redirect or reset.
REQ-029 Without STG0IA_HALT_EN: iw_halt port SHALL remain present but be ignored; HALT state SHALL be unreachable.

Verification
REQ-030 Reset release, mem_ready=1, no stall -> cycle 0 BOOT (valid=0), then ow_pc 0,1,2,3 with ow_ia_valid=1 each cycle.
REQ-031 RUN at pc=5, stall for 3 cycles -> ow_pc=5, ow_ia_valid=0 for 3 cycles, ow_mem_req=1; release -> 5 valid, then 6.
REQ-032 pc=9, branch_valid with target 0x40 and flush and stall same cycle -> valid=0; next cycle ow_pc=0x40, valid=1.
REQ-033 r_pc=all-ones, accepted fetch -> next ow_pc=0; mem_ready=0 at pc=2 for 2 cycles -> pc held at 2, no valid.
REQ-034 STG0IA_HALT_EN defined, halt at pc=7 -> ow_mem_req=0 from next cycle, pc stays 7; branch to 0x10 -> RUN, ow_pc=0x10; undefined -> halt ignored, pc keeps advancing.
REQ-035 Async reset asserted between edges while at pc=0x22 -> outputs zero immediately; after release BOOT then fetch from 0.
